jtframe_gain_ramp: RTL and testbench
====================================

Name: jtframe_gain_ramp

Overview:
- Gain controller for the 4-channel jtframe_mixer.
- Holds one CPU-written target gain per channel, in 4.4 fixed point.
- Drives the mixer gain0..gain3 inputs, ramping each toward its target at a programmable rate so volume changes and mute do not click.
- Sits between the game's sound-control registers and the mixer; the mixer itself is unchanged.

Parameters:
- RATEW, 12, width of the ramp-rate prescaler (counted in cen pulses).
- STEP, 1, gain LSBs added or subtracted per channel per ramp tick (1..255).
- RST_GAIN, 8'h10, reset value of all targets and outputs (1.0 in 4.4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- cen  in  1  sample-rate clock enable (same cen fed to the mixer)
- wr  in  1  target-write strobe, one clk wide
- wr_ch  in  2  channel addressed by the write
- wr_gain  in  8  new target gain, 4.4 unsigned
- wr_ack  out  1  one-clk pulse the cycle after wr is sampled
- rate  in  RATEW  cen pulses between ramp ticks; 0 = jump immediately
- mute  in  1  level; while high all effective targets are 0
- gain0, gain1, gain2, gain3  out  8  current gains to the mixer
- settled  out  1  high when every gainN equals its effective target

Behaviour:
- Reset: the design is a single clk domain; all state resets synchronously when rst_n=0 on a clk edge.
  - Targets and gain0..3 = RST_GAIN; prescaler = 0; pending = 0; FSM = IDLE.
  - wr_ack = 0; settled = 1.
  - Reset mid-ramp abandons the ramp with no partial update.
- Write port:
  - wr is always accepted; target[wr_ch] <= wr_gain; wr_ack = 1 on the next clk.
  - Back-to-back writes are legal, one per clk; the last write to a channel wins.
- Effective target: eff[n] = mute ? 0 : target[n]. Target registers are not cleared by mute, so releasing mute ramps back to the stored targets.
- Prescaler, advances only on cen:
  - cnt >= rate: tick, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - The >= comparison means lowering rate below cnt gives a tick on the next cen.
  - rate = 0 gives a tick on every cen.
- Tick handling: a tick sets pending. Ticks arriving while pending is already set merge into one, with no queueing.
- FSM: IDLE -> U0 -> U1 -> U2 -> U3 -> IDLE, one clk per state.
  - IDLE: if pending, clear it and go to U0.
  - Un updates channel n only:
    - If rate == 0: gain[n] <= eff[n].
    - Else if gain[n] < eff[n]: gain[n] <= gain[n] + min(STEP, eff[n] - gain[n]).
    - Else if gain[n] > eff[n]: gain[n] <= gain[n] - min(STEP, gain[n] - eff[n]).
  - The update never overshoots, and 8-bit arithmetic never wraps.
  - A tick during U0..U3 sets pending; a new sweep starts from IDLE.
- Latency:
  - Write to the first gain change: at most one tick period plus 5 clk.
  - A full sweep takes 4 clk, so cen must be at least 5 clk apart (jtframe audio cen is far slower). A faster cen only merges ticks.
- Simultaneous write and Un for the same channel: the update uses the pre-write target; the new target applies from the next sweep.
- mute toggling mid-sweep: each Un uses the mute level in its own cycle.
- settled is registered: it reflects the state after the previous clk's updates and drops the clk after any write or mute change that creates a mismatch.
- All outputs are registered, with no combinational path from inputs.

Decomposition:
- Shared package jtframe_gain_pkg holds:
  - GAIN_W = 8 and NCH = 4;
  - the FSM state enum (IDLE, U0..U3);
  - the 4.4 unity constant 8'h10.
- Natural sub-module: jtframe_gain_prescaler (cen counter plus tick/pending logic). The step arithmetic stays in the top.

Test Plan:
1. Reset: rst_n low 2 clk, release -> gain0..3 = 8'h10, settled = 1, wr_ack = 0; no change with no writes.
2. Ramp up: rate=3, STEP=1, write ch1 = 8'h14 -> wr_ack next clk; gain1 goes 11,12,13,14, one step every 4 cen; settled rises after 14; other channels stay 10.
3. Jump and no overshoot:
   - rate=0, write ch2 = 8'h40 -> gain2 = 40 within 5 clk of the next cen.
   - Then STEP=16, rate=1, write ch2 = 8'h05 -> 30, 20, 10, 05.
4. Mute: all targets 10, rate=0, mute=1 -> all gains 00 after one sweep; mute=0 -> back to 10; targets unchanged throughout.
5. Collision: wr ch0 = 8'h20 in exactly the U0 cycle (rate=0) -> gain0 stays 10 this sweep and becomes 20 on the next tick; wr_ack still pulses.
6. Reset mid-ramp: ch3 ramping 10 -> 80 at STEP=1, assert rst_n=0 at gain3 = 8'h30 -> next clk all gains 10, FSM IDLE, pending 0.

Source files
------------

// File: rtl/jtframe_gain_pkg.sv
// rtl/jtframe_gain_pkg.sv - shared constants and FSM states for the mixer gain ramp
package jtframe_gain_pkg;

  localparam int GAIN_W = 8;
  localparam int NCH    = 4;

  // 1.0 in 4.4 unsigned fixed point
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_U0,
    ST_U1,
    ST_U2,
    ST_U3
  } state_t;

endpackage

// File: rtl/jtframe_gain_prescaler.sv
// rtl/jtframe_gain_prescaler.sv - cen-driven ramp tick divider with a single pending flag
module jtframe_gain_prescaler #(
  parameter int RATEW = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cen,
  input  logic [RATEW-1:0] i_rate,
  input  logic             i_clr,
  output logic             o_pending
);

  logic [RATEW-1:0] r_cnt;
  logic             r_pending;
  logic             w_tick;

  // >= so that lowering rate below the running count still ticks promptly
  assign w_tick = i_cen && (r_cnt >= i_rate);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_cen) begin
        if (w_tick) r_cnt <= '0;
        else        r_cnt <= r_cnt + 1'b1;
      end
      // a tick landing on the consume cycle is kept rather than lost
      r_pending <= w_tick | (r_pending & ~i_clr);
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/jtframe_gain_ramp.sv
// rtl/jtframe_gain_ramp.sv - per-channel target gains ramped toward the mixer at a programmable rate
module jtframe_gain_ramp
  import jtframe_gain_pkg::*;
#(
  parameter int               RATEW    = 12,
  parameter int               STEP     = 1,
  parameter logic [GAIN_W-1:0] RST_GAIN = GAIN_UNITY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             wr,
  input  logic [1:0]       wr_ch,
  input  logic [7:0]       wr_gain,
  output logic             wr_ack,
  input  logic [RATEW-1:0] rate,
  input  logic             mute,
  output logic [7:0]       gain0,
  output logic [7:0]       gain1,
  output logic [7:0]       gain2,
  output logic [7:0]       gain3,
  output logic             settled
);

  localparam logic [GAIN_W-1:0] STEP_V = GAIN_W'(STEP);

  logic [GAIN_W-1:0] r_target [NCH];
  logic [GAIN_W-1:0] r_gain   [NCH];
  logic              r_ack;
  logic              r_settled;
  state_t            r_state;

  state_t            w_nxt_state;
  logic              w_pending;
  logic              w_clr;
  logic              w_upd;
  logic [1:0]        w_ch;
  logic [GAIN_W-1:0] w_cur;
  logic [GAIN_W-1:0] w_eff;
  logic [GAIN_W-1:0] w_up_diff;
  logic [GAIN_W-1:0] w_dn_diff;
  logic [GAIN_W-1:0] w_new;
  logic              w_match;

  jtframe_gain_prescaler #(
    .RATEW (RATEW)
  ) u_prescaler (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_cen     (cen),
    .i_rate    (rate),
    .i_clr     (w_clr),
    .o_pending (w_pending)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_clr       = 1'b0;
    w_upd       = 1'b0;
    w_ch        = 2'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending) begin
          w_clr       = 1'b1;
          w_nxt_state = ST_U0;
        end
      end
      ST_U0: begin
        w_upd       = 1'b1;
        w_ch        = 2'd0;
        w_nxt_state = ST_U1;
      end
      ST_U1: begin
        w_upd       = 1'b1;
        w_ch        = 2'd1;
        w_nxt_state = ST_U2;
      end
      ST_U2: begin
        w_upd       = 1'b1;
        w_ch        = 2'd2;
        w_nxt_state = ST_U3;
      end
      ST_U3: begin
        w_upd       = 1'b1;
        w_ch        = 2'd3;
        w_nxt_state = ST_IDLE;
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  // Saturating step toward the effective target; the register value is the pre-write target
  always_comb begin
    w_cur     = r_gain[w_ch];
    w_eff     = mute ? '0 : r_target[w_ch];
    w_up_diff = w_eff - w_cur;
    w_dn_diff = w_cur - w_eff;
    w_new     = w_cur;
    if (rate == '0)
      w_new = w_eff;
    else if (w_cur < w_eff)
      w_new = w_cur + ((w_up_diff < STEP_V) ? w_up_diff : STEP_V);
    else if (w_cur > w_eff)
      w_new = w_cur - ((w_dn_diff < STEP_V) ? w_dn_diff : STEP_V);
  end

  always_comb begin
    w_match = 1'b1;
    for (int n = 0; n < NCH; n++) begin
      if (r_gain[n] != (mute ? '0 : r_target[n])) w_match = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int n = 0; n < NCH; n++) begin
        r_target[n] <= RST_GAIN;
        r_gain[n]   <= RST_GAIN;
      end
      r_ack     <= 1'b0;
      r_settled <= 1'b1;
    end else begin
      r_ack     <= wr;
      r_settled <= w_match;
      if (wr)    r_target[wr_ch] <= wr_gain;
      if (w_upd) r_gain[w_ch]    <= w_new;
    end
  end

  assign wr_ack  = r_ack;
  assign settled = r_settled;
  assign gain0   = r_gain[0];
  assign gain1   = r_gain[1];
  assign gain2   = r_gain[2];
  assign gain3   = r_gain[3];

endmodule

// File: tb/tb_jtframe_gain_ramp.sv
// tb/tb_jtframe_gain_ramp.sv - randomized bench for jtframe_gain_ramp against a sweep-schedule model
module tb_jtframe_gain_ramp;

  localparam int RATEW = 12;
  localparam int STEP  = 5;
  localparam int RSTG  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cen = 1'b0;
  logic             wr = 1'b0;
  logic [1:0]       wr_ch = 2'd0;
  logic [7:0]       wr_gain = 8'd0;
  logic [RATEW-1:0] rate = '0;
  logic             mute = 1'b0;
  logic             wr_ack;
  logic             settled;
  logic [7:0]       gain0, gain1, gain2, gain3;

  jtframe_gain_ramp #(
    .RATEW    (RATEW),
    .STEP     (STEP),
    .RST_GAIN (8'h10)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cen     (cen),
    .wr      (wr),
    .wr_ch   (wr_ch),
    .wr_gain (wr_gain),
    .wr_ack  (wr_ack),
    .rate    (rate),
    .mute    (mute),
    .gain0   (gain0),
    .gain1   (gain1),
    .gain2   (gain2),
    .gain3   (gain3),
    .settled (settled)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a tick on cen edge k schedules channel n's update at edge k+2+n
  int m_target [4];
  int m_gain   [4];
  int m_due    [4];
  int m_cnt;
  bit m_ack;
  bit m_settled;
  int cen_wait = 3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff(input int n);
    return mute ? 0 : m_target[n];
  endfunction

  task automatic model_edge();
    bit match;
    int e, d;
    if (!rst_n) begin
      for (int n = 0; n < 4; n++) begin
        m_target[n] = RSTG;
        m_gain[n]   = RSTG;
        m_due[n]    = 0;
      end
      m_cnt     = 0;
      m_ack     = 1'b0;
      m_settled = 1'b1;
      return;
    end
    match = 1'b1;
    for (int n = 0; n < 4; n++) if (m_gain[n] != eff(n)) match = 1'b0;
    m_settled = match;
    for (int n = 0; n < 4; n++) begin
      if (m_due[n] > 0) begin
        m_due[n]--;
        if (m_due[n] == 0) begin
          e = eff(n);
          if (rate == 0) m_gain[n] = e;
          else if (m_gain[n] < e) begin
            d = e - m_gain[n];
            m_gain[n] += (d < STEP) ? d : STEP;
          end else if (m_gain[n] > e) begin
            d = m_gain[n] - e;
            m_gain[n] -= (d < STEP) ? d : STEP;
          end
        end
      end
    end
    if (cen) begin
      if (m_cnt >= int'(rate)) begin
        m_cnt = 0;
        for (int n = 0; n < 4; n++) m_due[n] = n + 2;
      end else begin
        m_cnt++;
      end
    end
    m_ack = wr;
    if (wr) m_target[wr_ch] = int'(wr_gain);
  endtask

  task automatic tick_clk();
    model_edge();
    @(negedge clk);
    check("gains", {gain3, gain2, gain1, gain0},
          {8'(m_gain[3]), 8'(m_gain[2]), 8'(m_gain[1]), 8'(m_gain[0])});
    check("wr_ack", {31'd0, wr_ack}, {31'd0, m_ack});
    check("settled", {31'd0, settled}, {31'd0, m_settled});
  endtask

  task automatic drive_cen();
    cen = (cen_wait == 0);
    if (cen_wait == 0) cen_wait = $urandom_range(5, 9);
    else cen_wait--;
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      drive_cen();
      tick_clk();
    end
    cen = 1'b0;
  endtask

  task automatic do_wr(input logic [1:0] ch, input logic [7:0] g);
    wr = 1'b1;
    wr_ch = ch;
    wr_gain = g;
    drive_cen();
    tick_clk();
    wr = 1'b0;
  endtask

  initial begin
    int rst_hold;
    rst_hold = 0;
    rst_n = 1'b0;
    tick_clk();
    tick_clk();
    rst_n = 1'b1;
    check("rst_gains", {gain3, gain2, gain1, gain0}, 32'h10101010);
    check("rst_settled", {31'd0, settled}, 32'd1);
    check("rst_ack", {31'd0, wr_ack}, 32'd0);
    run(40);

    rate = 3;
    do_wr(2'd1, 8'h14);
    check("ack_after_wr", {31'd0, wr_ack}, 32'd1);
    run(200);
    check("ramp_done", {gain3, gain2, gain1, gain0}, 32'h10101410);

    rate = 0;
    do_wr(2'd2, 8'h40);
    run(40);
    check("jump_done", {24'd0, gain2}, 32'h40);
    rate = 1;
    do_wr(2'd2, 8'h05);
    run(300);
    check("descend_done", {24'd0, gain2}, 32'h05);

    do_wr(2'd1, 8'h10);
    do_wr(2'd2, 8'h10);
    rate = 0;
    run(30);
    mute = 1'b1;
    run(30);
    check("mute_zero", {gain3, gain2, gain1, gain0}, 32'h0);
    mute = 1'b0;
    run(30);
    check("unmute", {gain3, gain2, gain1, gain0}, 32'h10101010);

    rate = 0;
    do_wr(2'd3, 8'h80);
    rate = 1;
    run(60);
    rst_n = 1'b0;
    tick_clk();
    rst_n = 1'b1;
    check("rst_mid_ramp", {gain3, gain2, gain1, gain0}, 32'h10101010);

    for (int i = 0; i < 6000; i++) begin
      drive_cen();
      wr = ($urandom_range(0, 3) == 0);
      wr_ch = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: wr_gain = 8'h00;
        1: wr_gain = 8'hFF;
        2: wr_gain = 8'h10;
        default: wr_gain = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 63) == 0) mute = ~mute;
      if ($urandom_range(0, 127) == 0) rate = RATEW'($urandom_range(0, 2));
      if (rst_hold > 0) begin
        rst_n = 1'b0;
        rst_hold--;
      end else begin
        rst_n = 1'b1;
        if ($urandom_range(0, 699) == 0) rst_hold = 2;
      end
      tick_clk();
    end
    wr = 1'b0;
    rst_n = 1'b1;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
